// File: rtl/ccip_c1tx_skid_pkg.sv
// ============================================================================
// Module      : ccip_c1tx_skid_pkg
// Description : Shared widths, defaults and the skid entry type for the
//               CCI-P channel-1 Tx skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ccip_c1tx_skid_pkg;

   localparam int c_hdr_w  = 80;
   localparam int c_data_w = 512;
   localparam int c_depth  = 8;

   typedef struct packed {
      logic [c_hdr_w-1:0]  hdr;
      logic [c_data_w-1:0] data;
   } t_c1tx_entry;

endpackage

`default_nettype wire

// File: rtl/ccip_c1tx_skid_ram.sv
// ============================================================================
// Module      : ccip_c1tx_skid_ram
// Description : DEPTH-entry register array, one write port, one async read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccip_c1tx_skid_ram
   import ccip_c1tx_skid_pkg::*;
#(
   parameter int DEPTH = c_depth
) (
   input  logic                       clk,
   input  logic                       i_we,
   input  logic [$clog2(DEPTH)-1:0]   i_waddr,
   input  t_c1tx_entry                i_wdata,
   input  logic [$clog2(DEPTH)-1:0]   i_raddr,
   output t_c1tx_entry                o_rdata
);

   // Contents are never reset; validity is tracked by the pointers in the parent.
   t_c1tx_entry r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/ccip_c1tx_skid.sv
// ============================================================================
// Module      : ccip_c1tx_skid
// Description : Skid buffer in front of CCI-P c1 Tx, pausing issue while the
//               registered almost-full is high. Optional statistics are built
//               when CCIP_C1TX_SKID_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccip_c1tx_skid
   import ccip_c1tx_skid_pkg::*;
#(
   parameter int DEPTH = c_depth,
   parameter int HDR_W = c_hdr_w
) (
   input  logic                     pClk,
   input  logic                     pck_cp2af_softReset_n,
   input  logic                     in_valid,
   input  logic [HDR_W-1:0]         in_hdr,
   input  logic [c_data_w-1:0]      in_data,
   output logic                     in_ready,
   input  logic                     c1TxAlmFull,
   output logic                     out_valid,
   output logic [HDR_W-1:0]         out_hdr,
   output logic [c_data_w-1:0]      out_data,
   output logic [$clog2(DEPTH):0]   occupancy
`ifdef CCIP_C1TX_SKID_STATS_EN
   ,
   output logic [31:0]              stat_stall_cycles,
   output logic [31:0]              stat_issued
`endif
);

   localparam int c_aw = $clog2(DEPTH);

   logic                  r_almfull_q;
   logic [c_aw:0]         r_occ;
   logic [c_aw-1:0]       r_wr_ptr;
   logic [c_aw-1:0]       r_rd_ptr;
   logic                  r_out_valid;
   logic [HDR_W-1:0]      r_out_hdr;
   logic [c_data_w-1:0]   r_out_data;

   logic                  w_push;
   logic                  w_pop;
   t_c1tx_entry           w_wr_entry;
   t_c1tx_entry           w_rd_entry;

   // DEPTH is a power of two, so the occupancy MSB is set only when full.
   assign in_ready   = ~r_occ[c_aw];
   assign w_push     = in_valid & in_ready;
   assign w_pop      = (r_occ != '0) & ~r_almfull_q;
   assign w_wr_entry = '{hdr: in_hdr, data: in_data};

   ccip_c1tx_skid_ram #(
      .DEPTH   (DEPTH)
   ) u_ram (
      .clk     (pClk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_wr_entry),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rd_entry)
   );

   always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
      if (!pck_cp2af_softReset_n) begin
         r_almfull_q <= 1'b0;
         r_occ       <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_out_valid <= 1'b0;
         r_out_hdr   <= '0;
         r_out_data  <= '0;
      end else begin
         r_almfull_q <= c1TxAlmFull;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_aw'(1);
         end
         if (w_pop) begin
            r_rd_ptr   <= r_rd_ptr + c_aw'(1);
            r_out_hdr  <= w_rd_entry.hdr;
            r_out_data <= w_rd_entry.data;
         end
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + (c_aw+1)'(1);
            2'b01:   r_occ <= r_occ - (c_aw+1)'(1);
            default: r_occ <= r_occ;
         endcase
         r_out_valid <= w_pop;
      end
   end

   assign out_valid = r_out_valid;
   assign out_hdr   = r_out_hdr;
   assign out_data  = r_out_data;
   assign occupancy = r_occ;

`ifdef CCIP_C1TX_SKID_STATS_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_issued;

   // Both counters stick at all-ones rather than wrapping.
   always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
      if (!pck_cp2af_softReset_n) begin
         r_stall_cycles <= '0;
         r_issued       <= '0;
      end else begin
         if ((r_occ != '0) && r_almfull_q && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
         end
         if (w_pop && (r_issued != 32'hFFFF_FFFF)) begin
            r_issued <= r_issued + 32'd1;
         end
      end
   end

   assign stat_stall_cycles = r_stall_cycles;
   assign stat_issued       = r_issued;
`endif

endmodule

`default_nettype wire
